// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: default widths and the
// FSM state encoding used by the top-level control logic.
package counter_seq_pkg;

   localparam int CNT_W_DEF   = 4;
   localparam int BURST_W_DEF = 8;
   localparam int WRAP_W_DEF  = 4;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CLEAR  = 3'd1;
   localparam logic [2:0] RUN    = 3'd2;
   localparam logic [2:0] PAUSED = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = IDLE,
      ST_CLEAR  = CLEAR,
      ST_RUN    = RUN,
      ST_PAUSED = PAUSED,
      ST_DONE   = DONE
   } state_t;

endpackage

// File: rtl/seq_burst_timer.sv
// Burst down-counter: loads the burst length, decrements once per enabled
// cycle and flags the last enabled cycle (value == 1) for the sequencer FSM.
module seq_burst_timer
   import counter_seq_pkg::*;
#(
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic [BURST_W-1:0] i_load_val,
   input  logic               i_dec,
   output logic [BURST_W-1:0] o_value,
   output logic               o_is_one
);

   localparam logic [BURST_W-1:0] ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
   localparam logic [BURST_W-1:0] ZERO = {BURST_W{1'b0}};

   logic [BURST_W-1:0] r_count;

   // Remaining-cycle register: load wins over decrement; never underflows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= ZERO;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != ZERO)) begin
         r_count <= r_count - ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_value  = r_count;
   assign o_is_one = (r_count == ONE);

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM sequencing one enable/reset counter: clear, run for a latched
// number of cycles, optional pause and abort, and a saturating wrap tally.
// All outputs come from registers or from the state register alone.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF,
   parameter int WRAP_W  = WRAP_W_DEF
) (
`ifdef USE_POWER_PINS
   inout  wire                vccd1,
   inout  wire                vssd1,
`endif
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               pause,
   input  logic               abort,
   input  logic [CNT_W-1:0]   cnt_value,
   output logic               cnt_enable,
   output logic               cnt_clear,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [BURST_W-1:0] remaining,
   output logic [WRAP_W-1:0]  wraps
);

   localparam logic [CNT_W-1:0]   CNT_ONES   = {CNT_W{1'b1}};
   localparam logic [WRAP_W-1:0]  WRAP_MAX   = {WRAP_W{1'b1}};
   localparam logic [WRAP_W-1:0]  WRAP_ONE   = {{(WRAP_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0]  WRAP_ZERO  = {WRAP_W{1'b0}};
   localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};

   state_t             r_state;
   state_t             w_next;
   logic               w_load;
   logic               w_dec;
   logic               w_abort_evt;
   logic               w_is_one;
   logic [BURST_W-1:0] w_remaining;
   logic               r_aborted;
   logic [WRAP_W-1:0]  r_wraps;

   // Remaining-cycle down-counter; it decrements in every RUN cycle,
   // including the cycle in which abort or pause is sampled.
   seq_burst_timer #(
      .BURST_W (BURST_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (burst_len),
      .i_dec      (w_dec),
      .o_value    (w_remaining),
      .o_is_one   (w_is_one)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; within RUN, abort beats completion beats pause.
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_abort_evt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (burst_len != BURST_ZERO) begin
                  w_load = 1'b1;
                  w_next = ST_CLEAR;
               end else begin
                  w_next = ST_DONE;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (abort) begin
               w_abort_evt = 1'b1;
               w_next      = ST_IDLE;
            end else begin
               w_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_abort_evt = 1'b1;
               w_next      = ST_IDLE;
            end else if (w_is_one) begin
               w_next = ST_DONE;
            end else if (pause) begin
               w_next = ST_PAUSED;
            end else begin
               w_next = ST_RUN;
            end
         end
         ST_PAUSED: begin
            if (abort) begin
               w_abort_evt = 1'b1;
               w_next      = ST_IDLE;
            end else if (!pause) begin
               w_next = ST_RUN;
            end else begin
               w_next = ST_PAUSED;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign w_dec = (r_state == ST_RUN);

   // Aborted pulse: registered so it appears in the cycle after the abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= w_abort_evt;
      end
   end

   // Wrap tally: an all-ones counter value in RUN wraps on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wraps <= WRAP_ZERO;
      end else if (w_load) begin
         r_wraps <= WRAP_ZERO;
      end else if ((r_state == ST_RUN) && (cnt_value == CNT_ONES) && (r_wraps != WRAP_MAX)) begin
         r_wraps <= r_wraps + WRAP_ONE;
      end else begin
         r_wraps <= r_wraps;
      end
   end

   assign cnt_enable = (r_state == ST_RUN);
   assign cnt_clear  = (r_state == ST_CLEAR);
   assign busy       = (r_state == ST_CLEAR) || (r_state == ST_RUN) || (r_state == ST_PAUSED);
   assign done       = (r_state == ST_DONE);
   assign aborted    = r_aborted;
   assign remaining  = w_remaining;
   assign wraps      = r_wraps;

endmodule
